// File: rtl/fpga_lab_sprint_pkg.sv
// Shared types and constants for the fpga_lab_sprint S00_AXI register slave.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package fpga_lab_sprint_pkg;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   localparam int REG_IDX_W = 2;
   localparam int NUM_REGS  = 4;

   typedef enum logic [1:0] {
      W_IDLE,
      W_WAIT_W,
      W_WAIT_AW,
      W_RESP
   } wr_state_t;

   typedef enum logic {
      R_IDLE,
      R_DATA
   } rd_state_t;

endpackage

// File: rtl/fpga_lab_sprint_s00_axi_regs.sv
// AXI4-Lite slave with 4 R/W registers, WSTRB byte enables and a per-register hardware load path.
// Latency: write commits on the completing AW/W edge with BVALID on that edge; read data registered 1 cycle after AR.
// Backpressure: one outstanding op per channel; BREADY/RREADY low stalls only its own channel.
module fpga_lab_sprint_s00_axi_regs
   import fpga_lab_sprint_pkg::*;
#(
   parameter int C_S_AXI_DATA_WIDTH = 32,
   parameter int C_S_AXI_ADDR_WIDTH = 4
) (
   input  logic                                   S_AXI_ACLK,
   input  logic                                   S_AXI_ARESETN,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]          S_AXI_AWADDR,
   input  logic [2:0]                             S_AXI_AWPROT,
   input  logic                                   S_AXI_AWVALID,
   output logic                                   S_AXI_AWREADY,
   input  logic [C_S_AXI_DATA_WIDTH-1:0]          S_AXI_WDATA,
   input  logic [C_S_AXI_DATA_WIDTH/8-1:0]        S_AXI_WSTRB,
   input  logic                                   S_AXI_WVALID,
   output logic                                   S_AXI_WREADY,
   output logic [1:0]                             S_AXI_BRESP,
   output logic                                   S_AXI_BVALID,
   input  logic                                   S_AXI_BREADY,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]          S_AXI_ARADDR,
   input  logic [2:0]                             S_AXI_ARPROT,
   input  logic                                   S_AXI_ARVALID,
   output logic                                   S_AXI_ARREADY,
   output logic [C_S_AXI_DATA_WIDTH-1:0]          S_AXI_RDATA,
   output logic [1:0]                             S_AXI_RRESP,
   output logic                                   S_AXI_RVALID,
   input  logic                                   S_AXI_RREADY,
   output logic [NUM_REGS*C_S_AXI_DATA_WIDTH-1:0] reg_out,
   input  logic [NUM_REGS-1:0]                    hw_load,
   input  logic [NUM_REGS*C_S_AXI_DATA_WIDTH-1:0] hw_data
);

   localparam int DW     = C_S_AXI_DATA_WIDTH;
   localparam int STRB_W = DW / 8;
   localparam int AW     = C_S_AXI_ADDR_WIDTH;

   // One past the last mapped byte address, widened so the compare works for any AW.
   localparam logic [AW:0] MAP_LIMIT = (AW + 1)'(NUM_REGS * 4);

   logic [DW-1:0]        regs_q [NUM_REGS];
   logic [DW-1:0]        regs_d [NUM_REGS];

   wr_state_t            wr_state_q, wr_state_d;
   rd_state_t            rd_state_q, rd_state_d;

   logic [AW-1:0]        awaddr_q;
   logic [DW-1:0]        wdata_q;
   logic [STRB_W-1:0]    wstrb_q;

   logic                 wr_commit, aw_latch, w_latch;
   logic [AW-1:0]        wr_addr;
   logic [DW-1:0]        wr_data;
   logic [STRB_W-1:0]    wr_strb;
   logic [REG_IDX_W-1:0] wr_idx, ar_idx;
   logic                 wr_mapped, ar_mapped, ar_hs;

   logic                 bvalid_q, rvalid_q;
   logic [1:0]           bresp_q, rresp_q;
   logic [DW-1:0]        rdata_q;

   // Protection bits carry no meaning for this register file.
   logic                 unused_prot;
   assign unused_prot = ^{S_AXI_AWPROT, S_AXI_ARPROT};

   assign wr_idx    = wr_addr[REG_IDX_W+1:2];
   assign ar_idx    = S_AXI_ARADDR[REG_IDX_W+1:2];
   assign wr_mapped = {1'b0, wr_addr} < MAP_LIMIT;
   assign ar_mapped = {1'b0, S_AXI_ARADDR} < MAP_LIMIT;

   // Write FSM next state, channel readies and selection of the committing address/data.
   always_comb begin
      wr_state_d    = wr_state_q;
      S_AXI_AWREADY = 1'b0;
      S_AXI_WREADY  = 1'b0;
      wr_commit     = 1'b0;
      aw_latch      = 1'b0;
      w_latch       = 1'b0;
      wr_addr       = awaddr_q;
      wr_data       = wdata_q;
      wr_strb       = wstrb_q;
      case (wr_state_q)
         W_IDLE: begin
            S_AXI_AWREADY = S_AXI_ARESETN;
            S_AXI_WREADY  = S_AXI_ARESETN;
            wr_addr       = S_AXI_AWADDR;
            wr_data       = S_AXI_WDATA;
            wr_strb       = S_AXI_WSTRB;
            if (S_AXI_AWVALID && S_AXI_WVALID) begin
               wr_commit  = 1'b1;
               wr_state_d = W_RESP;
            end else if (S_AXI_AWVALID) begin
               aw_latch   = 1'b1;
               wr_state_d = W_WAIT_W;
            end else if (S_AXI_WVALID) begin
               w_latch    = 1'b1;
               wr_state_d = W_WAIT_AW;
            end
         end
         W_WAIT_W: begin
            S_AXI_WREADY = S_AXI_ARESETN;
            wr_data      = S_AXI_WDATA;
            wr_strb      = S_AXI_WSTRB;
            if (S_AXI_WVALID) begin
               wr_commit  = 1'b1;
               wr_state_d = W_RESP;
            end
         end
         W_WAIT_AW: begin
            S_AXI_AWREADY = S_AXI_ARESETN;
            wr_addr       = S_AXI_AWADDR;
            if (S_AXI_AWVALID) begin
               wr_commit  = 1'b1;
               wr_state_d = W_RESP;
            end
         end
         W_RESP: begin
            if (S_AXI_BREADY) wr_state_d = W_IDLE;
         end
         default: wr_state_d = W_IDLE;
      endcase
   end

   // Write FSM state, half-transaction holding registers and the B channel.
   always_ff @(posedge S_AXI_ACLK) begin
      if (!S_AXI_ARESETN) begin
         wr_state_q <= W_IDLE;
         awaddr_q   <= '0;
         wdata_q    <= '0;
         wstrb_q    <= '0;
         bvalid_q   <= 1'b0;
         bresp_q    <= RESP_OKAY;
      end else begin
         wr_state_q <= wr_state_d;
         if (aw_latch) awaddr_q <= S_AXI_AWADDR;
         if (w_latch) begin
            wdata_q <= S_AXI_WDATA;
            wstrb_q <= S_AXI_WSTRB;
         end
         if (wr_commit) begin
            bvalid_q <= 1'b1;
            bresp_q  <= wr_mapped ? RESP_OKAY : RESP_SLVERR;
         end else if (bvalid_q && S_AXI_BREADY) begin
            bvalid_q <= 1'b0;
         end
      end
   end

   // Register next value: hw_load supplies the base, strobed AXI bytes override it.
   always_comb begin
      for (int i = 0; i < NUM_REGS; i++) begin
         regs_d[i] = hw_load[i] ? hw_data[i*DW +: DW] : regs_q[i];
         if (wr_commit && wr_mapped && (wr_idx == REG_IDX_W'(i))) begin
            for (int b = 0; b < STRB_W; b++) begin
               if (wr_strb[b]) regs_d[i][8*b +: 8] = wr_data[8*b +: 8];
            end
         end
      end
   end

   // Register storage.
   always_ff @(posedge S_AXI_ACLK) begin
      for (int i = 0; i < NUM_REGS; i++) begin
         regs_q[i] <= S_AXI_ARESETN ? regs_d[i] : '0;
      end
   end

   // Read FSM next state and AR ready.
   always_comb begin
      rd_state_d    = rd_state_q;
      S_AXI_ARREADY = 1'b0;
      ar_hs         = 1'b0;
      case (rd_state_q)
         R_IDLE: begin
            S_AXI_ARREADY = S_AXI_ARESETN;
            if (S_AXI_ARVALID) begin
               ar_hs      = 1'b1;
               rd_state_d = R_DATA;
            end
         end
         R_DATA: begin
            if (S_AXI_RREADY) rd_state_d = R_IDLE;
         end
         default: rd_state_d = R_IDLE;
      endcase
   end

   // Read FSM state and R channel; data samples pre-commit register contents.
   always_ff @(posedge S_AXI_ACLK) begin
      if (!S_AXI_ARESETN) begin
         rd_state_q <= R_IDLE;
         rvalid_q   <= 1'b0;
         rdata_q    <= '0;
         rresp_q    <= RESP_OKAY;
      end else begin
         rd_state_q <= rd_state_d;
         if (ar_hs) begin
            rvalid_q <= 1'b1;
            rdata_q  <= ar_mapped ? regs_q[ar_idx] : '0;
            rresp_q  <= ar_mapped ? RESP_OKAY : RESP_SLVERR;
         end else if (rvalid_q && S_AXI_RREADY) begin
            rvalid_q <= 1'b0;
         end
      end
   end

   for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg_out
      assign reg_out[g*DW +: DW] = regs_q[g];
   end

   assign S_AXI_BVALID = bvalid_q;
   assign S_AXI_BRESP  = bresp_q;
   assign S_AXI_RVALID = rvalid_q;
   assign S_AXI_RDATA  = rdata_q;
   assign S_AXI_RRESP  = rresp_q;

endmodule

// File: tb/tb_fpga_lab_sprint_s00_axi_regs.sv
// Bench for the S00_AXI register slave, built with a 5-bit address so 0x10..0x1F exercise SLVERR.
// Latency: n/a.
// Backpressure: BREADY/RREADY held high except in the stall sequence.
module tb_fpga_lab_sprint_s00_axi_regs;

   logic         clk;
   logic         S_AXI_ARESETN;
   logic [4:0]   S_AXI_AWADDR, S_AXI_ARADDR;
   logic [2:0]   S_AXI_AWPROT, S_AXI_ARPROT;
   logic         S_AXI_AWVALID, S_AXI_AWREADY;
   logic [31:0]  S_AXI_WDATA;
   logic [3:0]   S_AXI_WSTRB;
   logic         S_AXI_WVALID, S_AXI_WREADY;
   logic [1:0]   S_AXI_BRESP;
   logic         S_AXI_BVALID, S_AXI_BREADY;
   logic         S_AXI_ARVALID, S_AXI_ARREADY;
   logic [31:0]  S_AXI_RDATA;
   logic [1:0]   S_AXI_RRESP;
   logic         S_AXI_RVALID, S_AXI_RREADY;
   logic [127:0] reg_out;
   logic [3:0]   hw_load;
   logic [127:0] hw_data;

   int n_cmp = 0;
   int n_bad = 0;

   // Reference model: just the four register values.
   logic [31:0] mreg [4];

   fpga_lab_sprint_s00_axi_regs #(
      .C_S_AXI_DATA_WIDTH(32),
      .C_S_AXI_ADDR_WIDTH(5)
   ) dut (
      .S_AXI_ACLK(clk), .S_AXI_ARESETN(S_AXI_ARESETN),
      .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWPROT(S_AXI_AWPROT),
      .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
      .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB),
      .S_AXI_WVALID(S_AXI_WVALID), .S_AXI_WREADY(S_AXI_WREADY),
      .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID), .S_AXI_BREADY(S_AXI_BREADY),
      .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARPROT(S_AXI_ARPROT),
      .S_AXI_ARVALID(S_AXI_ARVALID), .S_AXI_ARREADY(S_AXI_ARREADY),
      .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP),
      .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY),
      .reg_out(reg_out), .hw_load(hw_load), .hw_data(hw_data)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic timeout_fail(input string name);
      n_cmp++;
      n_bad++;
      $display("FAIL %s: timed out waiting for handshake", name);
   endtask

   task automatic model_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s);
      if (a < 5'h10)
         for (int b = 0; b < 4; b++)
            if (s[b]) mreg[a[3:2]][8*b +: 8] = d[8*b +: 8];
   endtask

   task automatic model_read(input logic [4:0] a, output logic [31:0] d, output logic [1:0] r);
      d = (a < 5'h10) ? mreg[a[3:2]] : 32'h0;
      r = (a < 5'h10) ? 2'b00 : 2'b10;
   endtask

   function automatic logic [127:0] model_flat();
      return {mreg[3], mreg[2], mreg[1], mreg[0]};
   endfunction

   task automatic finish_b();
      int c = 0;
      while (!(S_AXI_BVALID && S_AXI_BREADY) && c < 50) begin
         @(posedge clk); #1; c++;
      end
      if (c >= 50) timeout_fail("b_handshake");
      @(posedge clk); #1;
      check("bvalid_clear", S_AXI_BVALID, 1'b0);
   endtask

   // All tasks start and end 1 time unit after a rising edge.
   task automatic do_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s,
                           input int aw_dly, input int w_dly, input bit wait_b,
                           output logic [1:0] resp);
      bit aw_done = 0, w_done = 0, aw_fire, w_fire;
      int c = 0;
      while (!(aw_done && w_done) && c < 50) begin
         S_AXI_AWADDR  = a;
         S_AXI_WDATA   = d;
         S_AXI_WSTRB   = s;
         S_AXI_AWVALID = !aw_done && (c >= aw_dly);
         S_AXI_WVALID  = !w_done && (c >= w_dly);
         #1;
         if (aw_done) begin
            check("awready_low_wait_w", S_AXI_AWREADY, 1'b0);
            check("wready_high_wait_w", S_AXI_WREADY, 1'b1);
         end
         if (w_done) begin
            check("wready_low_wait_aw", S_AXI_WREADY, 1'b0);
            check("awready_high_wait_aw", S_AXI_AWREADY, 1'b1);
         end
         aw_fire = S_AXI_AWVALID && S_AXI_AWREADY;
         w_fire  = S_AXI_WVALID && S_AXI_WREADY;
         @(posedge clk); #1;
         aw_done |= aw_fire;
         w_done  |= w_fire;
         c++;
      end
      S_AXI_AWVALID = 1'b0;
      S_AXI_WVALID  = 1'b0;
      if (c >= 50) timeout_fail("aw_w_handshake");
      model_write(a, d, s);
      check("bvalid_on_commit", S_AXI_BVALID, 1'b1);
      resp = S_AXI_BRESP;
      if (wait_b) finish_b();
   endtask

   task automatic read_issue(input logic [4:0] a, output logic [31:0] d, output logic [1:0] r);
      int c = 0;
      bit fired = 0;
      S_AXI_ARADDR  = a;
      S_AXI_ARVALID = 1'b1;
      while (!fired && c < 50) begin
         #1;
         fired = S_AXI_ARREADY;
         @(posedge clk); #1; c++;
      end
      S_AXI_ARVALID = 1'b0;
      if (!fired) timeout_fail("ar_handshake");
      check("rvalid_after_ar", S_AXI_RVALID, 1'b1);
      d = S_AXI_RDATA;
      r = S_AXI_RRESP;
   endtask

   task automatic read_finish();
      int c = 0;
      while (!(S_AXI_RVALID && S_AXI_RREADY) && c < 50) begin
         @(posedge clk); #1; c++;
      end
      if (c >= 50) timeout_fail("r_handshake");
      @(posedge clk); #1;
      check("rvalid_clear", S_AXI_RVALID, 1'b0);
   endtask

   task automatic do_read(input logic [4:0] a, output logic [31:0] d, output logic [1:0] r);
      read_issue(a, d, r);
      read_finish();
   endtask

   typedef struct {
      bit          wr;
      logic [4:0]  addr;
      logic [31:0] data;
      logic [3:0]  strb;
      logic [1:0]  resp;
      logic [31:0] rdata;
   } vec_t;

   vec_t tbl[17];

   initial begin
      logic [31:0] d, exp_d, held;
      logic [1:0]  r, exp_r;
      logic [4:0]  a;
      logic [3:0]  s, m;
      int          op;

      S_AXI_ARESETN = 1'b0;
      S_AXI_AWADDR = '0; S_AXI_ARADDR = '0; S_AXI_AWPROT = '0; S_AXI_ARPROT = '0;
      S_AXI_AWVALID = 0; S_AXI_WVALID = 0; S_AXI_ARVALID = 0;
      S_AXI_WDATA = '0; S_AXI_WSTRB = '0;
      S_AXI_BREADY = 1'b1; S_AXI_RREADY = 1'b1;
      hw_load = '0; hw_data = '0;
      for (int i = 0; i < 4; i++) mreg[i] = '0;

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      check("rst_awready", S_AXI_AWREADY, 1'b0);
      check("rst_arready", S_AXI_ARREADY, 1'b0);
      check("rst_bvalid", S_AXI_BVALID, 1'b0);
      check("rst_rvalid", S_AXI_RVALID, 1'b0);
      check("rst_rdata", S_AXI_RDATA, 32'h0);
      check("rst_reg_out", reg_out, 128'h0);
      S_AXI_ARESETN = 1'b1;
      @(posedge clk); #1;
      check("idle_awready", S_AXI_AWREADY, 1'b1);
      check("idle_wready", S_AXI_WREADY, 1'b1);
      check("idle_arready", S_AXI_ARREADY, 1'b1);

      // Directed vector table: full writes, strobes, ignored low address bits, SLVERR.
      tbl[0]  = '{1'b1, 5'h00, 32'h0000_0001, 4'hF, 2'b00, 32'h0};
      tbl[1]  = '{1'b1, 5'h04, 32'h0000_0002, 4'hF, 2'b00, 32'h0};
      tbl[2]  = '{1'b1, 5'h08, 32'h0000_0003, 4'hF, 2'b00, 32'h0};
      tbl[3]  = '{1'b1, 5'h0C, 32'h0000_0004, 4'hF, 2'b00, 32'h0};
      tbl[4]  = '{1'b0, 5'h00, 32'h0, 4'h0, 2'b00, 32'h0000_0001};
      tbl[5]  = '{1'b0, 5'h04, 32'h0, 4'h0, 2'b00, 32'h0000_0002};
      tbl[6]  = '{1'b0, 5'h08, 32'h0, 4'h0, 2'b00, 32'h0000_0003};
      tbl[7]  = '{1'b0, 5'h0C, 32'h0, 4'h0, 2'b00, 32'h0000_0004};
      tbl[8]  = '{1'b1, 5'h04, 32'hFFFF_FFFF, 4'hF, 2'b00, 32'h0};
      tbl[9]  = '{1'b1, 5'h04, 32'hAABB_CCDD, 4'h5, 2'b00, 32'h0};
      tbl[10] = '{1'b0, 5'h04, 32'h0, 4'h0, 2'b00, 32'hFFBB_FFDD};
      tbl[11] = '{1'b1, 5'h03, 32'h1234_5678, 4'hF, 2'b00, 32'h0};
      tbl[12] = '{1'b0, 5'h01, 32'h0, 4'h0, 2'b00, 32'h1234_5678};
      tbl[13] = '{1'b1, 5'h14, 32'hDEAD_BEEF, 4'hF, 2'b10, 32'h0};
      tbl[14] = '{1'b0, 5'h14, 32'h0, 4'h0, 2'b10, 32'h0};
      tbl[15] = '{1'b0, 5'h1C, 32'h0, 4'h0, 2'b10, 32'h0};
      tbl[16] = '{1'b0, 5'h04, 32'h0, 4'h0, 2'b00, 32'hFFBB_FFDD};
      for (int i = 0; i < 17; i++) begin
         if (tbl[i].wr) begin
            do_write(tbl[i].addr, tbl[i].data, tbl[i].strb, 0, 0, 1'b1, r);
            check($sformatf("tbl%0d_bresp", i), r, tbl[i].resp);
         end else begin
            do_read(tbl[i].addr, d, r);
            check($sformatf("tbl%0d_rdata", i), d, tbl[i].rdata);
            check($sformatf("tbl%0d_rresp", i), r, tbl[i].resp);
         end
      end
      check("tbl_reg_out", reg_out, {32'h4, 32'h3, 32'hFFBB_FFDD, 32'h1234_5678});

      // AW leads W by 3 cycles, then W leads AW, both on 0x8.
      do_write(5'h08, 32'hCAFE_0001, 4'hF, 0, 3, 1'b1, r);
      do_read(5'h08, d, r);
      check("aw_first_rdata", d, 32'hCAFE_0001);
      do_write(5'h08, 32'h0000_BEEF, 4'h3, 3, 0, 1'b1, r);
      do_read(5'h08, d, r);
      check("w_first_rdata", d, 32'hCAFE_BEEF);

      // Both responses stalled 10 cycles; further requests must not be accepted.
      S_AXI_BREADY = 1'b0;
      S_AXI_RREADY = 1'b0;
      do_write(5'h0C, 32'h5A5A_0000, 4'hF, 0, 0, 1'b0, r);
      read_issue(5'h0C, held, r);
      check("stall_rdata", held, 32'h5A5A_0000);
      S_AXI_AWVALID = 1; S_AXI_WVALID = 1; S_AXI_AWADDR = 5'h00;
      S_AXI_WDATA = 32'h7777_7777; S_AXI_WSTRB = 4'hF;
      S_AXI_ARVALID = 1; S_AXI_ARADDR = 5'h00;
      for (int k = 0; k < 10; k++) begin
         check("stall_awready", S_AXI_AWREADY, 1'b0);
         check("stall_wready", S_AXI_WREADY, 1'b0);
         check("stall_arready", S_AXI_ARREADY, 1'b0);
         check("stall_bvalid", S_AXI_BVALID, 1'b1);
         check("stall_rvalid", S_AXI_RVALID, 1'b1);
         check("stall_rdata_hold", S_AXI_RDATA, held);
         @(posedge clk); #1;
      end
      S_AXI_AWVALID = 0; S_AXI_WVALID = 0; S_AXI_ARVALID = 0;
      check("stall_no_commit", reg_out, model_flat());
      S_AXI_BREADY = 1'b1;
      S_AXI_RREADY = 1'b1;
      @(posedge clk); #1;
      check("stall_bvalid_clear", S_AXI_BVALID, 1'b0);
      check("stall_rvalid_clear", S_AXI_RVALID, 1'b0);

      // Write commit and AR to the same register on one edge: read sees the old value.
      do_write(5'h04, 32'h11, 4'hF, 0, 0, 1'b1, r);
      S_AXI_AWVALID = 1; S_AXI_WVALID = 1; S_AXI_AWADDR = 5'h04;
      S_AXI_WDATA = 32'h22; S_AXI_WSTRB = 4'hF;
      S_AXI_ARVALID = 1; S_AXI_ARADDR = 5'h04;
      @(posedge clk); #1;
      S_AXI_AWVALID = 0; S_AXI_WVALID = 0; S_AXI_ARVALID = 0;
      model_write(5'h04, 32'h22, 4'hF);
      check("coll_bvalid", S_AXI_BVALID, 1'b1);
      check("coll_rdata_old", S_AXI_RDATA, 32'h11);
      @(posedge clk); #1;
      check("coll_bvalid_clear", S_AXI_BVALID, 1'b0);
      check("coll_rvalid_clear", S_AXI_RVALID, 1'b0);
      do_read(5'h04, d, r);
      check("coll_rdata_new", d, 32'h22);

      // AXI write and hw_load on reg2 together; then hw_load alone on reg3.
      S_AXI_AWVALID = 1; S_AXI_WVALID = 1; S_AXI_AWADDR = 5'h08;
      S_AXI_WDATA = 32'h1234_5678; S_AXI_WSTRB = 4'h3;
      hw_load = 4'b0100; hw_data[95:64] = 32'hA5A5_A5A5;
      @(posedge clk); #1;
      S_AXI_AWVALID = 0; S_AXI_WVALID = 0; hw_load = '0;
      mreg[2] = 32'hA5A5_A5A5;
      model_write(5'h08, 32'h1234_5678, 4'h3);
      check("hwcoll_reg2", reg_out[95:64], 32'hA5A5_5678);
      finish_b();
      hw_load = 4'b1000; hw_data[127:96] = 32'hCAFE_F00D;
      @(posedge clk); #1;
      hw_load = '0;
      mreg[3] = 32'hCAFE_F00D;
      check("hwload_reg3", reg_out[127:96], 32'hCAFE_F00D);
      check("hwload_all", reg_out, model_flat());

      // Reset while waiting for W after an AW to 0xC.
      S_AXI_AWVALID = 1; S_AXI_AWADDR = 5'h0C;
      @(posedge clk); #1;
      S_AXI_AWVALID = 0;
      check("wait_w_awready", S_AXI_AWREADY, 1'b0);
      S_AXI_ARESETN = 1'b0;
      S_AXI_WVALID = 1; S_AXI_WDATA = 32'hFFFF_FFFF; S_AXI_WSTRB = 4'hF;
      repeat (2) begin @(posedge clk); #1; end
      S_AXI_WVALID = 0;
      S_AXI_ARESETN = 1'b1;
      for (int i = 0; i < 4; i++) mreg[i] = '0;
      #1;
      check("rstmid_awready", S_AXI_AWREADY, 1'b1);
      check("rstmid_wready", S_AXI_WREADY, 1'b1);
      check("rstmid_bvalid", S_AXI_BVALID, 1'b0);
      @(posedge clk); #1;
      check("rstmid_reg3", reg_out[127:96], 32'h0);
      check("rstmid_reg_out", reg_out, 128'h0);
      do_read(5'h14, d, r);
      check("unmapped_rresp", r, 2'b10);
      check("unmapped_rdata", d, 32'h0);

      // Randomized traffic against the model.
      for (int k = 0; k < 300; k++) begin
         op = $urandom_range(0, 5);
         a  = 5'($urandom_range(0, 31));
         if ($urandom_range(0, 3) != 0) a[4] = 1'b0;
         if (op <= 2) begin
            d = $urandom;
            s = 4'($urandom_range(0, 15));
            exp_r = (a < 5'h10) ? 2'b00 : 2'b10;
            do_write(a, d, s, $urandom_range(0, 3), $urandom_range(0, 3), 1'b1, r);
            check("rnd_bresp", r, exp_r);
         end else if (op <= 4) begin
            model_read(a, exp_d, exp_r);
            do_read(a, d, r);
            check("rnd_rdata", d, exp_d);
            check("rnd_rresp", r, exp_r);
         end else begin
            m = 4'($urandom_range(1, 15));
            for (int i = 0; i < 4; i++) hw_data[i*32 +: 32] = $urandom;
            hw_load = m;
            @(posedge clk); #1;
            hw_load = '0;
            for (int i = 0; i < 4; i++) if (m[i]) mreg[i] = hw_data[i*32 +: 32];
         end
         if (k % 10 == 9) check("rnd_reg_out", reg_out, model_flat());
      end
      check("final_reg_out", reg_out, model_flat());

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
